// File: rtl/switch_debounce_bank.sv
// switch_debounce_bank: multi-channel switch synchroniser and debouncer.
//
// Each of NUM_CH raw switch inputs passes through a two-flop synchroniser and a
// per-channel disagreement counter. A channel's stable level changes only after
// DEBOUNCE_LIMIT consecutive cycles in which the synchronised input differs from it.
// Registered one-cycle press/release pulses and an any-change flag are produced
// alongside the stable level so downstream FSMs need no edge detection.
//
// Optional build macro: SWITCH_DEBOUNCE_BANK_LONG_PRESS_EN
//   When defined, each channel also has a hold counter. o_Long pulses once,
//   LONG_LIMIT cycles after o_Press. When undefined, o_Long is tied to 0.

module switch_debounce_bank #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned COUNT_WIDTH    = 18,
  parameter int unsigned LONG_LIMIT     = 25000000,
  parameter int unsigned LONG_WIDTH     = 25
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_Switch,
  output logic [NUM_CH-1:0] o_Press,
  output logic [NUM_CH-1:0] o_Release,
  output logic              o_Any_Change,
  output logic [NUM_CH-1:0] o_Long
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("switch_debounce_bank: NUM_CH must be >= 1");
  end

  if (DEBOUNCE_LIMIT < 2) begin : g_bad_limit
    $error("switch_debounce_bank: DEBOUNCE_LIMIT must be >= 2");
  end

  if (COUNT_WIDTH < 1 ||
      (COUNT_WIDTH < 32 && (DEBOUNCE_LIMIT - 1) >= (32'd1 << COUNT_WIDTH))) begin : g_bad_width
    $error("switch_debounce_bank: COUNT_WIDTH cannot hold DEBOUNCE_LIMIT-1");
  end

  localparam logic [COUNT_WIDTH-1:0] CountMax = COUNT_WIDTH'(DEBOUNCE_LIMIT - 1);

  // ---------------------------------------------------------------------------
  // Registers and next-state wires
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0]      r_sync1;
  logic [NUM_CH-1:0]      r_sync2;
  logic [NUM_CH-1:0]      r_state;
  logic [NUM_CH-1:0]      r_press;
  logic [NUM_CH-1:0]      r_release;
  logic                   r_any;
  logic [COUNT_WIDTH-1:0] r_count [NUM_CH];

  logic [NUM_CH-1:0]      w_state_nxt;
  logic [NUM_CH-1:0]      w_rise;
  logic [NUM_CH-1:0]      w_fall;
  logic [COUNT_WIDTH-1:0] w_count_nxt [NUM_CH];

  // Two-flop synchroniser for the asynchronous switch pins
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_Switch;
      r_sync2 <= r_sync1;
    end
  end

  // Per-channel debounce decision: count disagreement, flip state at the limit
  always_comb begin
    w_state_nxt = r_state;
    w_rise      = '0;
    w_fall      = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      w_count_nxt[i] = r_count[i];
      if (r_sync2[i] == r_state[i]) begin
        // Any cycle of agreement discards the partial count.
        w_count_nxt[i] = '0;
      end else if (r_count[i] == CountMax) begin
        w_state_nxt[i] = r_sync2[i];
        w_count_nxt[i] = '0;
        w_rise[i]      = r_sync2[i];
        w_fall[i]      = ~r_sync2[i];
      end else begin
        w_count_nxt[i] = r_count[i] + 1'b1;
      end
    end
  end

  // Stable state, counters and registered transition pulses
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_any     <= 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        r_count[i] <= '0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_press   <= w_rise;
      r_release <= w_fall;
      r_any     <= |(w_rise | w_fall);
      for (int i = 0; i < int'(NUM_CH); i++) begin
        r_count[i] <= w_count_nxt[i];
      end
    end
  end

  assign o_Switch     = r_state;
  assign o_Press      = r_press;
  assign o_Release    = r_release;
  assign o_Any_Change = r_any;

`ifdef SWITCH_DEBOUNCE_BANK_LONG_PRESS_EN
  // ---------------------------------------------------------------------------
  // Long-press detection
  // ---------------------------------------------------------------------------
  if (LONG_LIMIT < 2) begin : g_bad_long_limit
    $error("switch_debounce_bank: LONG_LIMIT must be >= 2");
  end

  if (LONG_WIDTH < 1 ||
      (LONG_WIDTH < 32 && (LONG_LIMIT - 1) >= (32'd1 << LONG_WIDTH))) begin : g_bad_long_width
    $error("switch_debounce_bank: LONG_WIDTH cannot hold LONG_LIMIT-1");
  end

  localparam logic [LONG_WIDTH-1:0] HoldMax = LONG_WIDTH'(LONG_LIMIT - 1);

  logic [LONG_WIDTH-1:0] r_hold [NUM_CH];
  logic [NUM_CH-1:0]     r_long_done;
  logic [NUM_CH-1:0]     r_long;

  logic [LONG_WIDTH-1:0] w_hold_nxt [NUM_CH];
  logic [NUM_CH-1:0]     w_long_done_nxt;
  logic [NUM_CH-1:0]     w_long_nxt;

  // Hold counter runs while the stable level is high and saturates at HoldMax;
  // the done flag limits the long pulse to one per press.
  always_comb begin
    w_long_done_nxt = r_long_done;
    w_long_nxt      = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      w_hold_nxt[i] = r_hold[i];
      if (!r_state[i]) begin
        w_hold_nxt[i]      = '0;
        w_long_done_nxt[i] = 1'b0;
      end else if (r_hold[i] == HoldMax) begin
        w_long_nxt[i]      = ~r_long_done[i];
        w_long_done_nxt[i] = 1'b1;
      end else begin
        w_hold_nxt[i] = r_hold[i] + 1'b1;
      end
    end
  end

  // Long-press state registers
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_long_done <= '0;
      r_long      <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        r_hold[i] <= '0;
      end
    end else begin
      r_long_done <= w_long_done_nxt;
      r_long      <= w_long_nxt;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        r_hold[i] <= w_hold_nxt[i];
      end
    end
  end

  assign o_Long = r_long;
`else
  // Long-press parameters are kept in the parameter list so both builds share one
  // instantiation; they have no effect here.
  if (LONG_LIMIT == 0 && LONG_WIDTH == 0) begin : g_long_unused
  end

  assign o_Long = '0;
`endif

endmodule

// File: tb/tb_switch_debounce_bank.sv
// Directed bench for switch_debounce_bank (NUM_CH=2, DEBOUNCE_LIMIT=4).
// Expected per-cycle outputs are queued as stimulus is applied and popped after
// each rising edge for comparison.

module tb_switch_debounce_bank;

  localparam int unsigned NumCh = 2;

  typedef struct packed {
    logic [1:0] sw;
    logic [1:0] press;
    logic [1:0] rel;
    logic       any;
    logic [1:0] lng;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [NumCh-1:0] sw_in;
  logic [NumCh-1:0] o_sw;
  logic [NumCh-1:0] o_press;
  logic [NumCh-1:0] o_rel;
  logic             o_any;
  logic [NumCh-1:0] o_long;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  switch_debounce_bank #(
    .NUM_CH         (NumCh),
    .DEBOUNCE_LIMIT (4),
    .COUNT_WIDTH    (2),
    .LONG_LIMIT     (8),
    .LONG_WIDTH     (3)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Switch     (sw_in),
    .o_Switch     (o_sw),
    .o_Press      (o_press),
    .o_Release    (o_rel),
    .o_Any_Change (o_any),
    .o_Long       (o_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected long-press vector: only present when the feature is built in.
  function automatic logic [1:0] lp(input logic [1:0] v);
`ifdef SWITCH_DEBOUNCE_BANK_LONG_PRESS_EN
    return v;
`else
    return 2'b00 & v;
`endif
  endfunction

  task automatic push(input logic [1:0] sw, input logic [1:0] press, input logic [1:0] rel,
                      input logic any, input logic [1:0] lng, input int n);
    exp_t e;
    e.sw = sw; e.press = press; e.rel = rel; e.any = any; e.lng = lng;
    for (int k = 0; k < n; k++) exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, expv, $time);
    end
  endtask

  // Pop one expected entry and compare it with the current outputs.
  task automatic check_now();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1 t=%0t", $time);
      return;
    end
    e = exp_q.pop_front();
    chk("o_Switch",     o_sw,          e.sw);
    chk("o_Press",      o_press,       e.press);
    chk("o_Release",    o_rel,         e.rel);
    chk("o_Any_Change", {1'b0, o_any}, {1'b0, e.any});
    chk("o_Long",       o_long,        e.lng);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_now();
  endtask

  task automatic drain();
    while (exp_q.size() > 0) step();
  endtask

  initial begin
    rst_n = 1'b0;
    sw_in = 2'b11;

    // Reset: outputs held at zero while in reset
    #3;
    push(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1);
    check_now();
    push(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2);
    drain();

    // Release with both switches high: press 6 edges later, long 8 after press
    rst_n = 1'b1;
    push(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 5);
    push(2'b11, 2'b11, 2'b00, 1'b1, 2'b00, 1);
    push(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 7);
    push(2'b11, 2'b00, 2'b00, 1'b0, lp(2'b11), 1);
    push(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2);
    drain();

    // Release both channels together
    sw_in = 2'b00;
    push(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 5);
    push(2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 1);
    push(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2);
    drain();

    // Glitch rejection: channel 0 high for 3 cycles only
    sw_in = 2'b01;
    push(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1); step();
    push(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1); step();
    push(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1); step();
    sw_in = 2'b00;
    push(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 8);
    drain();

    // Bounce then settle on channel 1: 1,0,1,1,...
    sw_in = 2'b10;
    push(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1); step();
    sw_in = 2'b00;
    push(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1); step();
    sw_in = 2'b10;
    push(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 5);
    push(2'b10, 2'b10, 2'b00, 1'b1, 2'b00, 1);
    push(2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 7);
    push(2'b10, 2'b00, 2'b00, 1'b0, lp(2'b10), 1);
    push(2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 1);
    drain();

    // Independence: press channel 0 while channel 1 stays held; ch1 long must not repeat
    sw_in = 2'b11;
    push(2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 5);
    push(2'b11, 2'b01, 2'b00, 1'b1, 2'b00, 1);
    push(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 7);
    push(2'b11, 2'b00, 2'b00, 1'b0, lp(2'b01), 1);
    push(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 1);
    drain();

    // Drop channel 0 only
    sw_in = 2'b10;
    push(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 5);
    push(2'b10, 2'b00, 2'b01, 1'b1, 2'b00, 1);
    push(2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 2);
    drain();

    // Reset in the middle of a channel 0 mismatch count
    sw_in = 2'b11;
    push(2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 4);
    drain();
    rst_n = 1'b0;
    #1;
    push(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1);
    check_now();
    push(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2);
    drain();
    rst_n = 1'b1;
    push(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 5);
    push(2'b11, 2'b11, 2'b00, 1'b1, 2'b00, 1);
    push(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 7);
    push(2'b11, 2'b00, 2'b00, 1'b0, lp(2'b11), 1);
    push(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2);
    drain();

    // Release all, then a short press on channel 0 that must not give a long pulse
    sw_in = 2'b00;
    push(2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 5);
    push(2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 1);
    push(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2);
    drain();
    sw_in = 2'b01;
    push(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 5);
    push(2'b01, 2'b01, 2'b00, 1'b1, 2'b00, 1);
    drain();
    sw_in = 2'b00;
    push(2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 5);
    push(2'b00, 2'b00, 2'b01, 1'b1, 2'b00, 1);
    push(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 6);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
